// File: rtl/pam4_pkg.sv
// Shared types and helpers for the PAM-4 transmit channel model: level index type,
// index-to-voltage mapping and signed saturation.
package pam4_pkg;

  typedef logic [1:0] pam4_sym_t;

  // Level index 0..3 maps to -3S/2, -S/2, +S/2, +3S/2; sep is required to be even.
  function automatic int level_of(input pam4_sym_t idx, input int sep);
    return (2 * int'(idx) - 3) * (sep / 2);
  endfunction

  // Clamp v into the signed range of a width-bit two's complement value.
  function automatic int saturate(input int v, input int width);
    int max_v;
    int min_v;
    max_v = (1 << (width - 1)) - 1;
    min_v = -(1 << (width - 1));
    if (v > max_v) return max_v;
    if (v < min_v) return min_v;
    return v;
  endfunction

endpackage

// File: rtl/isi_fir.sv
// Post-cursor ISI FIR with saturation; history advances only on valid levels.
// Define ISI_SECOND_TAP_EN to add a second post-cursor tap of x[n-2] >>> (SHIFT+1).
module isi_fir
  import pam4_pkg::*;
#(
  parameter int W     = 8,
  parameter int SHIFT = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic signed [W-1:0] x_i,
  input  logic                x_valid_i,
  output logic signed [W-1:0] y_o,
  output logic                y_valid_o
);

  logic signed [W-1:0] xm1_q, xm1_d;
  logic signed [W-1:0] y_q, y_d;
  logic                y_valid_q, y_valid_d;
  logic signed [W+1:0] x_ext, tap1, sum;
`ifdef ISI_SECOND_TAP_EN
  logic signed [W-1:0] xm2_q, xm2_d;
  logic signed [W+1:0] tap2;
`endif

  always_comb begin
    // Sign-extend before shifting so the shift-add runs at W+2 bits without overflow.
    x_ext = x_i;
    tap1  = xm1_q;
    tap1  = tap1 >>> SHIFT;
    sum   = x_ext + tap1;
`ifdef ISI_SECOND_TAP_EN
    tap2  = xm2_q;
    tap2  = tap2 >>> (SHIFT + 1);
    sum   = sum + tap2;
    xm2_d = xm2_q;
`endif
    xm1_d     = xm1_q;
    y_d       = y_q;
    y_valid_d = x_valid_i;
    if (x_valid_i) begin
      y_d   = W'(saturate(int'(sum), W));
      xm1_d = x_i;
`ifdef ISI_SECOND_TAP_EN
      xm2_d = xm1_q;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      xm1_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
`ifdef ISI_SECOND_TAP_EN
      xm2_q     <= '0;
`endif
    end else begin
      xm1_q     <= xm1_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
`ifdef ISI_SECOND_TAP_EN
      xm2_q     <= xm2_d;
`endif
    end
  end

  assign y_o       = y_q;
  assign y_valid_o = y_valid_q;

endmodule

// File: rtl/pam4_isi_channel.sv
// PAM-4 transmit channel: pairs serial bits, Gray-codes them, maps to levels and applies ISI.
// ISI_SECOND_TAP_EN enables a second post-cursor tap inside isi_fir.
module pam4_isi_channel
  import pam4_pkg::*;
#(
  parameter int SIGNAL_RESOLUTION = 8,
  parameter int SYMBOL_SEPERATION = 56,
  parameter int ISI_SHIFT         = 2
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                data_in,
  input  logic                                data_in_valid,
  output logic signed [SIGNAL_RESOLUTION-1:0] signal_out,
  output logic                                signal_out_valid
);

  localparam int W = SIGNAL_RESOLUTION;

  logic                phase_q, phase_d;
  logic                b1_q, b1_d;
  pam4_sym_t           pair_q, pair_d;
  logic                pair_valid_q, pair_valid_d;
  pam4_sym_t           sym_q, sym_d;
  logic                sym_valid_q, sym_valid_d;
  logic signed [W-1:0] level_q, level_d;
  logic                level_valid_q, level_valid_d;

  always_comb begin
    phase_d      = phase_q;
    b1_d         = b1_q;
    pair_d       = pair_q;
    pair_valid_d = 1'b0;
    if (data_in_valid) begin
      phase_d = ~phase_q;
      if (!phase_q) begin
        b1_d = data_in;
      end else begin
        pair_d       = {b1_q, data_in};
        pair_valid_d = 1'b1;
      end
    end

    sym_d       = sym_q;
    sym_valid_d = pair_valid_q;
    if (pair_valid_q) sym_d = {pair_q[1], pair_q[1] ^ pair_q[0]};

    level_d       = level_q;
    level_valid_d = sym_valid_q;
    if (sym_valid_q) level_d = W'(level_of(sym_q, SYMBOL_SEPERATION));
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      phase_q       <= 1'b0;
      b1_q          <= 1'b0;
      pair_q        <= '0;
      pair_valid_q  <= 1'b0;
      sym_q         <= '0;
      sym_valid_q   <= 1'b0;
      level_q       <= '0;
      level_valid_q <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      b1_q          <= b1_d;
      pair_q        <= pair_d;
      pair_valid_q  <= pair_valid_d;
      sym_q         <= sym_d;
      sym_valid_q   <= sym_valid_d;
      level_q       <= level_d;
      level_valid_q <= level_valid_d;
    end
  end

  isi_fir #(
    .W     (W),
    .SHIFT (ISI_SHIFT)
  ) u_isi_fir (
    .clk_i     (clk),
    .rst_i     (rstn),
    .x_i       (level_q),
    .x_valid_i (level_valid_q),
    .y_o       (signal_out),
    .y_valid_o (signal_out_valid)
  );

endmodule

// File: tb/tb_pam4_isi_channel.sv
// Bench for pam4_isi_channel: table vectors, corner sequences, random stimulus vs a level model.
module tb_pam4_isi_channel;

  localparam int SR  = 8;
  localparam int SEP = 56;
  localparam int SH  = 2;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic data_in = 1'b0, data_in_valid = 1'b0;
  logic signed [SR-1:0] signal_out;
  logic signal_out_valid;
  logic sat_din = 1'b0, sat_dv = 1'b0;
  logic signed [SR-1:0] sat_out;
  logic sat_valid;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pam4_isi_channel #(
    .SIGNAL_RESOLUTION (SR),
    .SYMBOL_SEPERATION (SEP),
    .ISI_SHIFT         (SH)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .data_in          (data_in),
    .data_in_valid    (data_in_valid),
    .signal_out       (signal_out),
    .signal_out_valid (signal_out_valid)
  );

  pam4_isi_channel #(
    .SIGNAL_RESOLUTION (8),
    .SYMBOL_SEPERATION (80),
    .ISI_SHIFT         (0)
  ) dut_sat (
    .clk              (clk),
    .rstn             (rstn),
    .data_in          (sat_din),
    .data_in_valid    (sat_dv),
    .signal_out       (sat_out),
    .signal_out_valid (sat_valid)
  );

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (main DUT) ----------------
  typedef struct {int t; int y;} pend_t;
  pend_t pend[$];
  int cyc = 0;
  int m_phase = 0, m_b1 = 0, m_xm1 = 0, m_xm2 = 0, last_y = 0;
  bit chk_en = 1'b0;
  int gray_idx[4] = '{0, 1, 3, 2};

  function automatic int clamp8(input int v);
    return (v > 127) ? 127 : ((v < -128) ? -128 : v);
  endfunction

  task automatic model_step();
    int idx, x, y;
    cyc++;
    if (rstn) begin
      m_phase = 0; m_b1 = 0; m_xm1 = 0; m_xm2 = 0; last_y = 0;
      pend.delete();
    end else if (data_in_valid) begin
      if (m_phase == 0) begin
        m_b1 = int'(data_in);
      end else begin
        idx = gray_idx[m_b1 * 2 + int'(data_in)];
        x   = (2 * idx - 3) * SEP / 2;
        y   = x + (m_xm1 >>> SH);
`ifdef ISI_SECOND_TAP_EN
        y   = y + (m_xm2 >>> (SH + 1));
`endif
        m_xm2 = m_xm1;
        m_xm1 = x;
        pend.push_back('{cyc + 3, clamp8(y)});
      end
      m_phase = 1 - m_phase;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      if (pend.size() > 0 && pend[0].t == cyc) begin
        check("model_valid", signal_out_valid, 1);
        check("model_value", signal_out, pend[0].y);
        last_y = pend[0].y;
        void'(pend.pop_front());
      end else begin
        check("model_novalid", signal_out_valid, 0);
        check("model_hold", signal_out, last_y);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_bit(input logic b);
    data_in = b;
    data_in_valid = 1'b1;
    @(posedge clk);
    #1 data_in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      data_in = $urandom_range(0, 1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    rstn = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    rstn = 1'b0;
  endtask

  task automatic sat_pair(input logic b1, input logic b0, input int exp, input string name);
    sat_din = b1; sat_dv = 1'b1;
    @(posedge clk);
    #1 sat_din = b0;
    @(posedge clk);
    #1 sat_dv = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({name, "_valid"}, sat_valid, 1);
    check(name, sat_out, exp);
  endtask

  typedef struct {bit rst_before; bit b1; bit b0; int gap; int exp_y;} vec_t;
  vec_t vecs[8];

  initial begin
    int exp_tab[4];
`ifdef ISI_SECOND_TAP_EN
    exp_tab = '{-84, 63, -18, 31};
`else
    exp_tab = '{-84, 63, -7, 21};
`endif
    for (int i = 0; i < 8; i++) begin
      vecs[i].rst_before = (i == 4);
      vecs[i].gap        = (i < 4) ? 0 : 3;
      vecs[i].exp_y      = exp_tab[i % 4];
    end
    // Pairs 00, 10, 01, 11 (symbols 0, 3, 1, 2)
    for (int i = 0; i < 8; i++) begin
      vecs[i].b1 = (i % 4 == 1) || (i % 4 == 3);
      vecs[i].b0 = (i % 4 == 2) || (i % 4 == 3);
    end

    // Reset while inputs toggle
    rstn = 1'b1;
    @(posedge clk);
    #1 chk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = i[0];
      data_in_valid = 1'b1;
      @(negedge clk);
      check("reset_out", signal_out, 0);
      check("reset_valid", signal_out_valid, 0);
      @(posedge clk);
      #1;
    end
    data_in_valid = 1'b0;
    rstn = 1'b0;
    idle(2);

    // Table-driven pairs; second half repeats with gaps after a reset
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].rst_before) begin
        do_reset(1);
        idle(2);
      end
      send_bit(vecs[i].b1);
      idle(vecs[i].gap);
      send_bit(vecs[i].b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), signal_out_valid, 1);
      check($sformatf("vec%0d_value", i), signal_out, vecs[i].exp_y);
      idle(vecs[i].gap);
    end

    // Mid-pair reset discards the held bit and clears history
    idle(2);
    send_bit(1'b1);
    do_reset(1);
    send_bit(1'b0);
    send_bit(1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midreset_valid", signal_out_valid, 1);
    check("midreset_value", signal_out, -84);

`ifdef ISI_SECOND_TAP_EN
    // Symbols 3,0,0 exercise the second tap
    idle(1);
    do_reset(1);
    send_bit(1'b1); send_bit(1'b0);
    send_bit(1'b0); send_bit(1'b0);
    send_bit(1'b0); send_bit(1'b0);
    idle(4);
    check("tap2_last", signal_out, -95);
`endif

    // Saturation on the S=80, shift=0 instance
    idle(1);
    do_reset(1);
    sat_pair(1'b1, 1'b0, 120, "sat_first_pos");
    sat_pair(1'b1, 1'b0, 127, "sat_clamp_pos");
    do_reset(1);
    sat_pair(1'b0, 1'b0, -120, "sat_first_neg");
    sat_pair(1'b0, 1'b0, -128, "sat_clamp_neg");

    // Randomised traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      rstn          = ($urandom_range(0, 249) == 0);
      data_in_valid = ($urandom_range(0, 9) < 7);
      data_in       = $urandom_range(0, 1);
      @(posedge clk);
      #1;
    end
    rstn = 1'b0;
    data_in_valid = 1'b0;
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
